// File: rtl/game_grid_pkg.sv
// Shared types and colour defaults for the board-grid overlay stage.
// The vga_bus_t bundle is the pixel stream passed along the VGA chain.
package game_grid_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0] rgb_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  typedef struct packed {
    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   blank;
    rgb_t   rgb;
  } vga_bus_t;

  localparam rgb_t THIN_DEF      = 12'h777;
  localparam rgb_t THICK_DEF     = 12'hfff;
  localparam rgb_t INCORRECT_DEF = 12'hf77;
  localparam rgb_t CURSOR_DEF    = 12'h0f0;

endpackage

// File: rtl/game_grid_axis.sv
// One axis of the grid: pixel-in-cell, cell index and box sub-counters.
// Classification is for the coordinate presented this cycle.
module game_grid_axis
  import game_grid_pkg::*;
#(
  parameter int CELL_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  coord_t     coord_i,
  input  coord_t     origin_i,
  input  coord_t     span_i,
  input  logic [2:0] n_i,
  input  logic       load_i,
  input  logic       step_i,
  output logic       in_range_o,
  output logic       is_line_o,
  output logic       is_thick_o,
  output logic [4:0] cell_idx_o
);

  localparam int PW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;

  logic [PW-1:0] pix_q, pix_d;
  logic [4:0]    cell_q, cell_d;
  logic [2:0]    box_q, box_d;
  coord_t        far_edge;
  logic          at_edge;

  // The _d values describe the current pixel and become the held state.
  always_comb begin
    pix_d  = pix_q;
    cell_d = cell_q;
    box_d  = box_q;
    if (load_i) begin
      pix_d  = '0;
      cell_d = '0;
      box_d  = '0;
    end else if (step_i) begin
      if (pix_q == PW'(CELL_SIZE - 1)) begin
        pix_d  = '0;
        cell_d = cell_q + 5'd1;
        if (box_q == n_i - 3'd1) begin
          box_d = '0;
        end else begin
          box_d = box_q + 3'd1;
        end
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q  <= '0;
      cell_q <= '0;
      box_q  <= '0;
    end else begin
      pix_q  <= pix_d;
      cell_q <= cell_d;
      box_q  <= box_d;
    end
  end

  always_comb begin
    far_edge   = origin_i + span_i;
    at_edge    = (coord_i == far_edge);
    in_range_o = (coord_i >= origin_i) && (coord_i <= far_edge);
    is_line_o  = in_range_o && ((pix_d == '0) || at_edge);
    is_thick_o = is_line_o && ((box_d == '0) || at_edge);
    cell_idx_o = cell_d;
  end

endmodule

// File: rtl/game_grid_draw.sv
// Centred N^2 x N^2 grid overlay with cursor blink and incorrect flash.
// Two-cycle pipeline: classify, then colour mux.
module game_grid_draw
  import game_grid_pkg::*;
#(
  parameter int   SCREEN_WIDTH    = 1024,
  parameter int   SCREEN_HEIGHT   = 768,
  parameter int   CELL_SIZE       = 16,
  parameter int   MAX_BOARD_SIZE  = 4,
  parameter int   BLINK_FRAMES    = 30,
  parameter int   FLASH_FRAMES    = 60,
  parameter rgb_t THIN_COLOR      = THIN_DEF,
  parameter rgb_t THICK_COLOR     = THICK_DEF,
  parameter rgb_t INCORRECT_COLOR = INCORRECT_DEF,
  parameter rgb_t CURSOR_COLOR    = CURSOR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_game_on,
  input  logic [2:0] board_size,
  input  logic [4:0] cursor_x,
  input  logic [4:0] cursor_y,
  input  logic       incorrect,
  input  vga_bus_t   bus_in,
  output vga_bus_t   bus_out
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic tick;
  assign tick = (bus_in.hcount == '0) &&
                (bus_in.vcount == '0);

  logic [2:0] n_q, n_d;
  logic [4:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;

  always_comb begin
    n_d  = tick ? board_size : n_q;
    cx_d = tick ? cursor_x : cx_q;
    cy_d = tick ? cursor_y : cy_q;
  end

  coord_t nn, span, x0, y0;
  logic   n_ok;

  always_comb begin
    nn   = coord_t'(n_q) * coord_t'(n_q);
    span = nn * coord_t'(CELL_SIZE);
    x0   = (coord_t'(SCREEN_WIDTH) - span) >> 1;
    y0   = (coord_t'(SCREEN_HEIGHT) - span) >> 1;
    n_ok = (n_q >= 3'd2) &&
           (n_q <= 3'(MAX_BOARD_SIZE));
  end

  logic       x_in, x_line, x_thick;
  logic       y_in, y_line, y_thick;
  logic [4:0] x_cell, y_cell;
  logic       x_load, y_load, y_step;

  assign x_load = (bus_in.hcount == x0);
  assign y_step = (bus_in.hcount == '0);
  assign y_load = y_step && (bus_in.vcount == y0);

  game_grid_axis #(
    .CELL_SIZE (CELL_SIZE)
  ) u_x (
    .clk        (clk),
    .rst        (rst),
    .coord_i    (bus_in.hcount),
    .origin_i   (x0),
    .span_i     (span),
    .n_i        (n_q),
    .load_i     (x_load),
    .step_i     (1'b1),
    .in_range_o (x_in),
    .is_line_o  (x_line),
    .is_thick_o (x_thick),
    .cell_idx_o (x_cell)
  );

  game_grid_axis #(
    .CELL_SIZE (CELL_SIZE)
  ) u_y (
    .clk        (clk),
    .rst        (rst),
    .coord_i    (bus_in.vcount),
    .origin_i   (y0),
    .span_i     (span),
    .n_i        (n_q),
    .load_i     (y_load),
    .step_i     (y_step),
    .in_range_o (y_in),
    .is_line_o  (y_line),
    .is_thick_o (y_thick),
    .cell_idx_o (y_cell)
  );

  logic       phase_q, phase_d;
  logic [BW-1:0] blink_q, blink_d;

  always_comb begin
    phase_d = phase_q;
    blink_d = blink_q;
    if (tick) begin
      if (blink_q == BW'(BLINK_FRAMES - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  logic [5:0] cx1, cy1;
  logic       cur_ok;
  logic       x_at, x_at1, y_at, y_at1;
  logic       x_edge, y_edge, x_span, y_span;
  logic       cur_hit, both_in, line_px, thick_px;

  // The cursor cell spans both of its bounding lines on each axis.
  always_comb begin
    cx1      = {1'b0, cx_q} + 6'd1;
    cy1      = {1'b0, cy_q} + 6'd1;
    cur_ok   = (coord_t'(cx_q) < nn) &&
               (coord_t'(cy_q) < nn);
    x_at     = (x_cell == cx_q);
    x_at1    = ({1'b0, x_cell} == cx1);
    y_at     = (y_cell == cy_q);
    y_at1    = ({1'b0, y_cell} == cy1);
    x_edge   = x_line && (x_at || x_at1);
    y_edge   = y_line && (y_at || y_at1);
    x_span   = x_in && (x_at || (x_at1 && x_line));
    y_span   = y_in && (y_at || (y_at1 && y_line));
    cur_hit  = phase_q && cur_ok &&
               ((x_edge && y_span) ||
                (y_edge && x_span));
    both_in  = x_in && y_in;
    line_px  = both_in && (x_line || y_line);
    thick_px = both_in && (x_thick || y_thick);
  end

  flash_state_t  state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          inc_q, rise;

  assign rise = incorrect && !inc_q;

  // A fresh rising edge always reloads, even on the expiring frame.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!is_game_on) begin
      state_d = IDLE;
      fcnt_d  = '0;
    end else if (rise) begin
      state_d = FLASH;
      fcnt_d  = FW'(FLASH_FRAMES);
    end else if (state_q == FLASH && tick) begin
      if (fcnt_q <= FW'(1)) begin
        state_d = IDLE;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
      end
    end
  end

  vga_bus_t s1_bus_q, out_q;
  logic     s1_en_q, s1_cur_q, s1_line_q;
  logic     s1_thick_q, s1_inc_q;
  rgb_t     rgb_d;

  always_comb begin
    rgb_d = s1_bus_q.rgb;
    if (s1_en_q) begin
      if (s1_cur_q) begin
        rgb_d = CURSOR_COLOR;
      end else if (s1_line_q && s1_inc_q) begin
        rgb_d = INCORRECT_COLOR;
      end else if (s1_thick_q) begin
        rgb_d = THICK_COLOR;
      end else if (s1_line_q) begin
        rgb_d = THIN_COLOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      phase_q    <= 1'b1;
      blink_q    <= '0;
      state_q    <= IDLE;
      fcnt_q     <= '0;
      inc_q      <= 1'b0;
      s1_bus_q   <= '0;
      s1_en_q    <= 1'b0;
      s1_cur_q   <= 1'b0;
      s1_line_q  <= 1'b0;
      s1_thick_q <= 1'b0;
      s1_inc_q   <= 1'b0;
      out_q      <= '0;
    end else begin
      n_q        <= n_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      phase_q    <= phase_d;
      blink_q    <= blink_d;
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      inc_q      <= incorrect;
      s1_bus_q   <= bus_in;
      s1_en_q    <= is_game_on && n_ok;
      s1_cur_q   <= cur_hit;
      s1_line_q  <= line_px;
      s1_thick_q <= thick_px;
      s1_inc_q   <= incorrect || (state_q == FLASH);
      out_q      <= s1_bus_q;
      out_q.rgb  <= rgb_d;
    end
  end

  assign bus_out = out_q;

endmodule
